// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared instruction-memory parameters and load sequencer state type
package imem_pkg;

    localparam int INSTR_LENGTH = 32;
    localparam int MEM_DEPTH    = 128;
    localparam int ADDR_WIDTH   = $clog2(MEM_DEPTH);

    // MEM_DEPTH expressed at load_len width so range checks stay width-exact
    localparam logic [ADDR_WIDTH:0] MEM_DEPTH_LEN = MEM_DEPTH[ADDR_WIDTH:0];

    localparam logic [INSTR_LENGTH-1:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/imem_load_ctrl_if.sv
// rtl/imem_load_ctrl_if.sv - byte stream and imem port bundle between loader and its environment
// master: the load controller (consumes rx bytes and fetch_addr, drives the imem port)
// slave : byte source / imem / core side
//   rx_data, rx_valid, rx_ready  program byte handshake
//   fetch_addr                   core instruction fetch address
//   mem_addr, mem_we, mem_wdata  imem address and write port
interface imem_load_ctrl_if;
    import imem_pkg::*;

    logic [7:0]              rx_data;
    logic                    rx_valid;
    logic                    rx_ready;
    logic [ADDR_WIDTH-1:0]   fetch_addr;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic                    mem_we;
    logic [INSTR_LENGTH-1:0] mem_wdata;

    modport master (
        input  rx_data, rx_valid, fetch_addr,
        output rx_ready, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        output rx_data, rx_valid, fetch_addr,
        input  rx_ready, mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/imem_word_packer.sv
// rtl/imem_word_packer.sv - packs four bytes little-endian into one instruction word
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   clear       return byte index to 0 and drop any partial word
//   byte_valid  a byte is accepted this cycle
//   byte_data   the accepted byte
//   word        assembled word; valid together with word_valid
//   word_valid  the 4th byte of a word is being accepted this cycle
module imem_word_packer
    import imem_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    byte_valid,
    input  logic [7:0]              byte_data,
    output logic [INSTR_LENGTH-1:0] word,
    output logic                    word_valid
);

    logic [1:0]  idx;
    logic [23:0] low_bytes;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= 2'd0;
            low_bytes <= 24'd0;
        end else if (clear) begin
            idx       <= 2'd0;
            low_bytes <= 24'd0;
        end else if (byte_valid) begin
            // index wraps 3 -> 0 on its own, so the next word starts cleanly
            idx <= idx + 2'd1;
            case (idx)
                2'd0:    low_bytes[7:0]   <= byte_data;
                2'd1:    low_bytes[15:8]  <= byte_data;
                2'd2:    low_bytes[23:16] <= byte_data;
                default: ;
            endcase
        end
    end

    // the top byte is taken straight from the input so the word is ready
    // in the same cycle as the 4th handshake
    assign word       = {byte_data, low_bytes};
    assign word_valid = byte_valid && (idx == 2'd3);

endmodule

// File: rtl/imem_load_ctrl.sv
// rtl/imem_load_ctrl.sv - run-time instruction memory loader with core stall and imem address mux
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   bus          byte stream in, fetch address in, imem address/write port out
//   load_start   one-cycle load request, honoured only in IDLE
//   load_len     words to load, sampled with load_start
//   core_hold    stall the core while a load is in progress
//   busy         any state other than IDLE
//   done         one-cycle pulse at load completion
//   err          sticky out-of-range load_len flag, cleared by the next accepted start
module imem_load_ctrl
    import imem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    imem_load_ctrl_if.master      bus,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH:0]   load_len,
    output logic                  core_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    state_t                  state;
    state_t                  state_n;
    logic [ADDR_WIDTH-1:0]   wptr;
    logic [ADDR_WIDTH:0]     len_q;
    logic                    err_q;
    logic                    we_q;
    logic [INSTR_LENGTH-1:0] wdata_q;

    logic                    in_idle;
    logic                    len_zero;
    logic                    len_ok;
    logic                    start_accept;
    logic                    last_word;
    logic                    byte_acc;
    logic [INSTR_LENGTH-1:0] pk_word;
    logic                    pk_word_valid;

    assign in_idle      = (state == IDLE);
    assign len_zero     = (load_len == '0);
    assign len_ok       = !len_zero && (load_len <= MEM_DEPTH_LEN);
    // a zero-length start is accepted too: it clears err and pulses done
    assign start_accept = in_idle && load_start && (len_ok || len_zero);
    assign byte_acc     = bus.rx_valid && (state == COLLECT);
    // compare at load_len width so a 128-word load ends before wptr wraps
    assign last_word    = (({1'b0, wptr} + (ADDR_WIDTH+1)'(1)) == len_q);

    imem_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (in_idle),
        .byte_valid (byte_acc),
        .byte_data  (bus.rx_data),
        .word       (pk_word),
        .word_valid (pk_word_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (load_start) begin
                    if (len_zero) begin
                        state_n = DONE;
                    end else if (len_ok) begin
                        state_n = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (pk_word_valid) begin
                    state_n = WRITE;
                end
            end
            WRITE: begin
                state_n = last_word ? DONE : COLLECT;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            // mem_we is a flop that is high exactly while the FSM sits in WRITE
            we_q <= (state_n == WRITE);

            if (in_idle && load_start) begin
                err_q <= !(len_ok || len_zero);
            end

            if (start_accept) begin
                wptr  <= '0;
                len_q <= load_len;
            end else if (state == WRITE) begin
                wptr <= wptr + 1'b1;
            end

            if ((state == COLLECT) && pk_word_valid) begin
                wdata_q <= pk_word;
            end
        end
    end

    assign bus.rx_ready  = (state == COLLECT);
    assign bus.mem_addr  = in_idle ? bus.fetch_addr : wptr;
    assign bus.mem_we    = we_q;
    assign bus.mem_wdata = wdata_q;

    assign busy      = !in_idle;
    assign core_hold = !in_idle;
    assign done      = (state == DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb/tb_imem_load_ctrl.sv - self-checking bench for imem_load_ctrl
module tb_imem_load_ctrl;
    import imem_pkg::*;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                load_start = 1'b0;
    logic [ADDR_WIDTH:0] load_len = '0;
    logic                core_hold;
    logic                busy;
    logic                done;
    logic                err;

    imem_load_ctrl_if bus ();

    imem_load_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.master),
        .load_start (load_start),
        .load_len   (load_len),
        .core_hold  (core_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [ADDR_WIDTH-1:0]   wr_addr[$];
    logic [INSTR_LENGTH-1:0] wr_data[$];
    int done_cnt = 0;
    int ready_viol = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_we) begin
                wr_addr.push_back(bus.mem_addr);
                wr_data.push_back(bus.mem_wdata);
            end
            if (done) done_cnt++;
            if (bus.rx_ready && (bus.mem_we || done || !busy)) ready_viol++;
        end
    end

    logic [7:0] src [0:511];
    int nsrc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_pattern(input int pat);
        logic [7:0] prog [0:7];
        prog = '{8'h13, 8'h01, 8'h01, 8'hfe, 8'h23, 8'h2e, 8'h11, 8'h00};
        case (pat)
            0: begin
                for (int i = 0; i < 8; i++) src[i] = prog[i];
                nsrc = 8;
            end
            1: begin
                src[0] = 8'h13; src[1] = 8'h00; src[2] = 8'h00; src[3] = 8'h00;
                nsrc = 4;
            end
            2: begin
                for (int i = 0; i < 512; i++) src[i] = 8'((i * 37 + 5) & 255);
                nsrc = 512;
            end
            default: begin
                src[0] = 8'haa; src[1] = 8'hbb; src[2] = 8'hcc; src[3] = 8'hdd;
                nsrc = 4;
            end
        endcase
    endtask

    // Issues load_start, feeds src[] and returns at the done pulse, after
    // stop_after accepted bytes, or when the cycle budget runs out.
    task automatic run_load(input logic [7:0] len, input bit toggle, input bit exp_hold,
                            input int budget, input int stop_after,
                            output int lat, output int hold_viol);
        int  i = 0;
        int  t0;
        bit  acc = 1'b0;
        lat       = -1;
        hold_viol = 0;
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
        @(negedge clk);
        load_start   = 1'b1;
        load_len     = len;
        bus.rx_valid = 1'b0;
        t0 = cyc;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            if (acc) i++;
            @(negedge clk);
            load_start = 1'b0;
            if (done) begin
                lat = cyc - t0;
                break;
            end
            if (core_hold !== exp_hold) hold_viol++;
            if (stop_after >= 0 && i >= stop_after) break;
            bus.rx_valid = (i < nsrc) && (!toggle || (c % 2 == 0));
            bus.rx_data  = (i < nsrc) ? src[i] : 8'h00;
            #1;
            acc = bus.rx_valid && bus.rx_ready;
        end
        bus.rx_valid = 1'b0;
        load_start   = 1'b0;
    endtask

    typedef struct {
        logic [7:0] len;
        int         pat;
        bit         toggle;
        bit         exp_done;
        bit         exp_err;
        int         exp_nwr;
        int         exp_lat;
    } vec_t;

    vec_t vecs [0:5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int hold_viol;
        bus.fetch_addr = 7'd5;
        bus.rx_valid   = 1'b0;
        bus.rx_data    = 8'h00;
        rst            = 1'b1;

        #1;
        check("reset rx_ready",  64'(bus.rx_ready),  64'd0);
        check("reset mem_we",    64'(bus.mem_we),    64'd0);
        check("reset mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check("reset core_hold", 64'(core_hold),     64'd0);
        check("reset busy",      64'(busy),          64'd0);
        check("reset done",      64'(done),          64'd0);
        check("reset err",       64'(err),           64'd0);
        check("reset mem_addr",  64'(bus.mem_addr),  64'd5);

        @(negedge clk);
        rst = 1'b0;
        bus.fetch_addr = 7'd9;

        vecs[0] = '{8'd2,   0, 1'b0, 1'b1, 1'b0,   2,  11};
        vecs[1] = '{8'd2,   0, 1'b1, 1'b1, 1'b0,   2,  -1};
        vecs[2] = '{8'd129, 0, 1'b0, 1'b0, 1'b1,   0,  -1};
        vecs[3] = '{8'd1,   1, 1'b0, 1'b1, 1'b0,   1,   6};
        vecs[4] = '{8'd0,   0, 1'b0, 1'b1, 1'b0,   0,   1};
        vecs[5] = '{8'd128, 2, 1'b0, 1'b1, 1'b0, 128, 641};

        for (int v = 0; v < 6; v++) begin
            load_pattern(vecs[v].pat);
            run_load(vecs[v].len, vecs[v].toggle, vecs[v].exp_done,
                     vecs[v].exp_done ? (12 * int'(vecs[v].len) + 20) : 10, -1,
                     lat, hold_viol);
            @(negedge clk);
            if (vecs[v].exp_done && lat < 0)
                check($sformatf("v%0d done timeout", v), 64'd1, 64'd0);
            if (vecs[v].exp_lat >= 0)
                check($sformatf("v%0d done latency", v), 64'(lat), 64'(vecs[v].exp_lat));
            check($sformatf("v%0d done count", v), 64'(done_cnt), 64'(vecs[v].exp_done));
            check($sformatf("v%0d core_hold", v), 64'(hold_viol), 64'd0);
            check($sformatf("v%0d err", v), 64'(err), 64'(vecs[v].exp_err));
            check($sformatf("v%0d busy after", v), 64'(busy), 64'd0);
            check($sformatf("v%0d mem_addr idle", v), 64'(bus.mem_addr), 64'd9);
            check($sformatf("v%0d writes", v), 64'(wr_addr.size()), 64'(vecs[v].exp_nwr));
            for (int k = 0; k < wr_addr.size() && k < vecs[v].exp_nwr; k++) begin
                check($sformatf("v%0d w%0d addr", v, k), 64'(wr_addr[k]), 64'(k));
                check($sformatf("v%0d w%0d data", v, k), 64'(wr_data[k]),
                      64'({src[4*k+3], src[4*k+2], src[4*k+1], src[4*k]}));
            end
        end

        // reset lands after 2 bytes of word 3
        load_pattern(2);
        run_load(8'd4, 1'b0, 1'b1, 60, 14, lat, hold_viol);
        check("midreset writes before", 64'(wr_addr.size()), 64'd3);
        #2;
        rst = 1'b1;
        #1;
        check("midreset mem_we",    64'(bus.mem_we),    64'd0);
        check("midreset mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check("midreset busy",      64'(busy),          64'd0);
        check("midreset core_hold", 64'(core_hold),     64'd0);
        check("midreset rx_ready",  64'(bus.rx_ready),  64'd0);
        check("midreset mem_addr",  64'(bus.mem_addr),  64'd9);
        @(negedge clk);
        rst = 1'b0;

        load_pattern(3);
        run_load(8'd1, 1'b0, 1'b1, 40, -1, lat, hold_viol);
        @(negedge clk);
        check("restart done latency", 64'(lat), 64'd6);
        check("restart writes", 64'(wr_addr.size()), 64'd1);
        if (wr_addr.size() > 0) begin
            check("restart addr", 64'(wr_addr[0]), 64'd0);
            check("restart data", 64'(wr_data[0]), 64'h00000000ddccbbaa);
        end

        check("rx_ready outside collect", 64'(ready_viol), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
